// File: rtl/comp_or_reduce_pipe.sv
// comp_or_reduce_pipe: two-stage masked OR reduction across N channels of W bits,
// with optional sticky accumulation across beats and a saturating beat counter.
// A ready/valid handshake is used on both sides; the whole pipeline stalls together
// when the output register is full and not being drained.
module comp_or_reduce_pipe #(
   parameter int W  = 8,
   parameter int N  = 4,
   parameter int CW = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [N*W-1:0] in_data,
   input  logic [N-1:0]   in_mask,
   input  logic           acc_mode,
   input  logic           clear,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [W-1:0]   out_data,
   output logic           out_any,
   output logic [CW-1:0]  out_count
);

   localparam int H = N / 2;

   // Counter increment that sticks at all-ones instead of wrapping.
   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
      return (&c) ? c : c + CW'(1);
   endfunction

   logic [W-1:0]  lo_c, hi_c;
   logic          vld_p1;
   logic [W-1:0]  lo_p1, hi_p1;
   logic          acc_mode_p1, clear_p1;
   logic [W-1:0]  r_c, data_c;
   logic [CW-1:0] count_c;
   logic          vld_p2;
   logic [W-1:0]  data_p2, acc_p2;
   logic [CW-1:0] count_p2, acc_cnt_p2;

   // Everything advances together; a full, undrained output blocks all stages.
   assign in_ready = ~(vld_p2 & ~out_ready);

   // Masked OR of the lower and upper halves of the channels.
   always_comb begin
      lo_c = '0;
      hi_c = '0;
      for (int k = 0; k < N; k++) begin
         if (in_mask[k]) begin
            if (k < H) lo_c = lo_c | in_data[k*W +: W];
            else       hi_c = hi_c | in_data[k*W +: W];
         end
      end
   end

   // ---- stage 1: half reductions and beat controls ----
   // Stage-1 register; holds while stalled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p1      <= 1'b0;
         lo_p1       <= '0;
         hi_p1       <= '0;
         acc_mode_p1 <= 1'b0;
         clear_p1    <= 1'b0;
      end else if (in_ready) begin
         vld_p1      <= in_valid;
         lo_p1       <= lo_c;
         hi_p1       <= hi_c;
         acc_mode_p1 <= acc_mode;
         clear_p1    <= clear;
      end
   end

   // Final reduction, accumulation and beat count for the stage-1 beat.
   // acc_cnt_p2 is zero outside accumulation, so a switch into acc_mode
   // naturally restarts the count at 1.
   always_comb begin
      r_c     = lo_p1 | hi_p1;
      data_c  = r_c;
      count_c = CW'(1);
      if (acc_mode_p1 && !clear_p1) begin
         data_c  = r_c | acc_p2;
         count_c = sat_inc(acc_cnt_p2);
      end
   end

   // ---- stage 2: output register and accumulator ----
   // Output/accumulator register; bubbles drop out_valid, acc holds.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p2     <= 1'b0;
         data_p2    <= '0;
         count_p2   <= '0;
         acc_p2     <= '0;
         acc_cnt_p2 <= '0;
      end else if (in_ready) begin
         if (vld_p1) begin
            vld_p2     <= 1'b1;
            data_p2    <= data_c;
            count_p2   <= count_c;
            acc_p2     <= acc_mode_p1 ? data_c : '0;
            acc_cnt_p2 <= acc_mode_p1 ? count_c : '0;
         end else begin
            vld_p2 <= 1'b0;
         end
      end
   end

   assign out_valid = vld_p2;
   assign out_data  = data_p2;
   assign out_count = count_p2;
   assign out_any   = |data_p2;

endmodule

// File: tb/tb_comp_or_reduce_pipe.sv
// Testbench for comp_or_reduce_pipe: a default instance (CW=8) and a CW=2
// instance driven by the same stimulus; directed vectors plus stall and reset
// sequences.
module tb_comp_or_reduce_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [31:0] in_data;
   logic [3:0]  in_mask;
   logic        acc_mode, clear, out_ready;
   logic        in_ready, out_valid, out_any;
   logic [7:0]  out_data, out_count;
   logic        in_ready2, out_valid2, out_any2;
   logic [7:0]  out_data2;
   logic [1:0]  out_count2;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   comp_or_reduce_pipe #(.W(8), .N(4), .CW(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_mask(in_mask), .acc_mode(acc_mode), .clear(clear),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_any(out_any), .out_count(out_count));

   comp_or_reduce_pipe #(.W(8), .N(4), .CW(2)) dut2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
      .in_data(in_data), .in_mask(in_mask), .acc_mode(acc_mode), .clear(clear),
      .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
      .out_any(out_any2), .out_count(out_count2));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        mode;
      logic        clr;
      logic [3:0]  mask;
      logic [31:0] data;
      logic [7:0]  exp_d;
      logic [7:0]  exp_c;
      logic [1:0]  exp_c2;
   } vec_t;

   localparam int NV = 16;
   vec_t tv[NV];

   logic [7:0] q[$];
   logic [7:0] held_d, held_c, exp_v;
   int idx, got;

   initial begin
      // mode clr mask data(ch3..ch0) -> data, count(CW=8), count(CW=2)
      tv[0]  = '{1'b0, 1'b0, 4'b1111, 32'h40040201, 8'h47, 8'd1, 2'd1};
      tv[1]  = '{1'b0, 1'b0, 4'b0101, 32'h80018002, 8'h03, 8'd1, 2'd1};
      tv[2]  = '{1'b1, 1'b1, 4'b1111, 32'h00000010, 8'h10, 8'd1, 2'd1};
      tv[3]  = '{1'b1, 1'b0, 4'b1111, 32'h00000100, 8'h11, 8'd2, 2'd2};
      tv[4]  = '{1'b1, 1'b0, 4'b1111, 32'h20000000, 8'h31, 8'd3, 2'd3};
      tv[5]  = '{1'b1, 1'b1, 4'b1111, 32'h00040000, 8'h04, 8'd1, 2'd1};
      tv[6]  = '{1'b1, 1'b0, 4'b0000, 32'hFFFFFFFF, 8'h04, 8'd2, 2'd2};
      tv[7]  = '{1'b0, 1'b0, 4'b1111, 32'h00000008, 8'h08, 8'd1, 2'd1};
      tv[8]  = '{1'b1, 1'b0, 4'b1000, 32'h80000000, 8'h80, 8'd1, 2'd1};
      tv[9]  = '{1'b1, 1'b0, 4'b0010, 32'h00000100, 8'h81, 8'd2, 2'd2};
      tv[10] = '{1'b0, 1'b0, 4'b0000, 32'hFFFFFFFF, 8'h00, 8'd1, 2'd1};
      tv[11] = '{1'b1, 1'b1, 4'b1111, 32'h00000001, 8'h01, 8'd1, 2'd1};
      tv[12] = '{1'b1, 1'b0, 4'b1111, 32'h00000200, 8'h03, 8'd2, 2'd2};
      tv[13] = '{1'b1, 1'b0, 4'b1111, 32'h00040000, 8'h07, 8'd3, 2'd3};
      tv[14] = '{1'b1, 1'b0, 4'b1111, 32'h08000000, 8'h0F, 8'd4, 2'd3};
      tv[15] = '{1'b1, 1'b0, 4'b1111, 32'h00000010, 8'h1F, 8'd5, 2'd3};

      rst = 1'b1; in_valid = 1'b0; in_data = '0; in_mask = '0;
      acc_mode = 1'b0; clear = 1'b0; out_ready = 1'b1;
      #12;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_any", out_any, 0);
      check("rst_out_count", out_count, 0);
      check("rst_in_ready", in_ready, 1);
      @(negedge clk) rst = 1'b0;

      // Streaming vectors, out_ready=1: output of beat c appears in cycle c+2.
      for (int c = 0; c < NV + 2; c++) begin
         @(posedge clk); #1;
         if (c < NV) begin
            in_valid = 1'b1; acc_mode = tv[c].mode; clear = tv[c].clr;
            in_mask = tv[c].mask; in_data = tv[c].data;
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
         if (c < 2) begin
            check($sformatf("lat_valid_c%0d", c), out_valid, 0);
         end else begin
            check($sformatf("v%0d_valid", c - 2), out_valid, 1);
            check($sformatf("v%0d_data", c - 2), out_data, tv[c-2].exp_d);
            check($sformatf("v%0d_any", c - 2), out_any, tv[c-2].exp_d != 0);
            check($sformatf("v%0d_count", c - 2), out_count, tv[c-2].exp_c);
            check($sformatf("v%0d_valid2", c - 2), out_valid2, 1);
            check($sformatf("v%0d_data2", c - 2), out_data2, tv[c-2].exp_d);
            check($sformatf("v%0d_any2", c - 2), out_any2, tv[c-2].exp_d != 0);
            check($sformatf("v%0d_count2", c - 2), out_count2, tv[c-2].exp_c2);
         end
      end

      repeat (3) @(posedge clk);

      // Backpressure: out_ready low for 3 cycles while streaming 8 beats.
      idx = 0; got = 0;
      held_d = '0; held_c = '0;
      for (int c = 0; c < 30; c++) begin
         @(posedge clk); #1;
         out_ready = !(c >= 4 && c < 7);
         acc_mode = 1'b0; clear = 1'b0; in_mask = 4'b1111;
         if (idx < 8) begin
            in_valid = 1'b1; in_data = {24'h0, 8'(8'h20 + idx)};
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
         if (c >= 4 && c < 7) begin
            check($sformatf("stall_in_ready_c%0d", c), in_ready, 0);
            check($sformatf("stall_in_ready2_c%0d", c), in_ready2, 0);
            check($sformatf("stall_out_valid_c%0d", c), out_valid, 1);
         end
         if (c == 4) begin
            held_d = out_data; held_c = out_count;
         end
         if (c == 5 || c == 6) begin
            check($sformatf("stall_hold_data_c%0d", c), out_data, held_d);
            check($sformatf("stall_hold_count_c%0d", c), out_count, held_c);
         end
         if (in_valid && in_ready) begin
            q.push_back(in_data[7:0]);
            idx++;
         end
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               check("stall_extra_output", out_data, 8'hEE);
            end else begin
               exp_v = q.pop_front();
               check($sformatf("stall_beat%0d", got), out_data, exp_v);
            end
            got++;
         end
      end
      check("stall_beats_out", got, 8);
      check("stall_queue_left", q.size(), 0);

      // Reset mid-stream: build up acc, then reset with two beats in flight.
      @(posedge clk); #1;
      out_ready = 1'b1; in_valid = 1'b1; acc_mode = 1'b1; clear = 1'b1;
      in_mask = 4'b1111; in_data = 32'h00000030;
      @(posedge clk); #1;
      clear = 1'b0; in_data = 32'h00004000;
      @(posedge clk); #1;
      in_data = 32'h00080000;
      @(negedge clk);
      check("pre_rst_data", out_data, 8'h30);
      rst = 1'b1; in_valid = 1'b0;
      #1;
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_in_ready", in_ready, 1);
      check("mid_rst_out_data", out_data, 0);
      check("mid_rst_out_count", out_count, 0);
      @(negedge clk) rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check($sformatf("post_rst_idle_c%0d", c), out_valid, 0);
      end
      @(posedge clk); #1;
      in_valid = 1'b1; acc_mode = 1'b1; clear = 1'b0; in_data = 32'h00000005;
      @(negedge clk);
      check("post_rst_lat0", out_valid, 0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      check("post_rst_lat1", out_valid, 0);
      @(negedge clk);
      check("post_rst_valid", out_valid, 1);
      check("post_rst_data", out_data, 8'h05);
      check("post_rst_count", out_count, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
